// File: rtl/opt_pkg.sv
// rtl/opt_pkg.sv - shared pricing constants, FSM state type and width helper
package opt_pkg;

    localparam int PRICE_W   = 16;
    localparam int FRAC_BITS = 8;
    localparam int INT_BITS  = PRICE_W - FRAC_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/payoff_accumulator_if.sv
// rtl/payoff_accumulator_if.sv - run control, path stream and price result bundle
interface payoff_accumulator_if;
    import opt_pkg::*;

    logic               start;
    logic [PRICE_W-1:0] strike;
    logic               put_sel;
    logic               path_valid;
    logic [PRICE_W-1:0] path;
    logic               busy;
    logic               price_valid;
    logic [PRICE_W-1:0] price;

    modport master (
        output start, strike, put_sel, path_valid, path,
        input  busy, price_valid, price
    );

    modport slave (
        input  start, strike, put_sel, path_valid, path,
        output busy, price_valid, price
    );

endinterface

// File: rtl/payoff_unit.sv
// rtl/payoff_unit.sv - combinational European payoff max(S-K,0) or max(K-S,0)
module payoff_unit
    import opt_pkg::*;
(
    input  logic [PRICE_W-1:0] s,
    input  logic [PRICE_W-1:0] k,
    input  logic               put_sel,
    output logic [PRICE_W-1:0] payoff
);

    always_comb begin
        payoff = '0;
        if (put_sel) begin
            if (k > s) payoff = k - s;
        end else begin
            if (s > k) payoff = s - k;
        end
    end

endmodule

// File: rtl/payoff_accumulator.sv
// rtl/payoff_accumulator.sv - Monte-Carlo option price accumulator; ASIAN_PAYOFF_EN selects average-price payoff
module payoff_accumulator
    import opt_pkg::*;
#(
    parameter int N_STEPS = 64,
    parameter int N_PATHS = 1024
)(
    input  logic                 clk,
    input  logic                 rst_n,
    payoff_accumulator_if.slave  bus
);

    localparam int SW    = cnt_w(N_STEPS);
    localparam int PW    = cnt_w(N_PATHS);
    localparam int ACC_W = PRICE_W + PW;

    state_t             state, state_nx;
    logic [PRICE_W-1:0] strike_q;
    logic               put_q;
    logic [SW-1:0]      step_cnt;
    logic [PW-1:0]      path_cnt;
    logic [ACC_W-1:0]   acc, acc_sum;
    logic [PRICE_W-1:0] pay_q, pay_nx, s_eff;
    logic               pay_vld;
    logic               start_ok, sample, terminal, last_path;

    assign start_ok  = bus.start && (state == IDLE || state == DONE);
    assign sample    = bus.path_valid && (state == RUN);
    assign terminal  = sample && (step_cnt == SW'(N_STEPS - 1));
    assign last_path = terminal && (path_cnt == PW'(N_PATHS - 1));
    assign acc_sum   = pay_vld ? acc + ACC_W'(pay_q) : acc;

`ifdef ASIAN_PAYOFF_EN
    logic [PRICE_W+SW-1:0] path_sum, sum_nx;
    // Include the current sample so the terminal cycle sees the full-path average.
    assign sum_nx = path_sum + (PRICE_W+SW)'(bus.path);
    assign s_eff  = sum_nx[PRICE_W+SW-1:SW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               path_sum <= '0;
        else if (start_ok)        path_sum <= '0;
        else if (sample)          path_sum <= terminal ? '0 : sum_nx;
    end
`else
    assign s_eff = bus.path;
`endif

    payoff_unit u_payoff (
        .s       (s_eff),
        .k       (strike_q),
        .put_sel (put_q),
        .payoff  (pay_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        bus.busy = 1'b0;
        case (state)
            IDLE, DONE: if (bus.start) state_nx = RUN;
            RUN: begin
                bus.busy = 1'b1;
                if (last_path) state_nx = FINISH;
            end
            FINISH: begin
                bus.busy = 1'b1;
                state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strike_q        <= '0;
            put_q           <= 1'b0;
            step_cnt        <= '0;
            path_cnt        <= '0;
            acc             <= '0;
            pay_q           <= '0;
            pay_vld         <= 1'b0;
            bus.price       <= '0;
            bus.price_valid <= 1'b0;
        end else begin
            bus.price_valid <= 1'b0;
            if (start_ok) begin
                strike_q <= bus.strike;
                put_q    <= bus.put_sel;
                step_cnt <= '0;
                path_cnt <= '0;
                acc      <= '0;
                pay_vld  <= 1'b0;
            end else begin
                pay_vld <= terminal;
                acc     <= acc_sum;
                if (sample)   step_cnt <= step_cnt + 1'b1;
                if (terminal) begin
                    path_cnt <= path_cnt + 1'b1;
                    pay_q    <= pay_nx;
                end
                // FINISH carries the last path's payoff, so fold it in directly.
                if (state == FINISH) begin
                    bus.price       <= acc_sum[ACC_W-1:PW];
                    bus.price_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_payoff_accumulator.sv
// tb/tb_payoff_accumulator.sv - directed self-checking bench for payoff_accumulator (N_STEPS=4, N_PATHS=4)
module tb_payoff_accumulator;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic [15:0] smp [16];
    logic [15:0] prev_price;

    always #5 clk = ~clk;

    payoff_accumulator_if bus ();

    payoff_accumulator #(.N_STEPS(4), .N_PATHS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill_term(input logic [15:0] a, b, c, d);
        logic [15:0] t [4];
        t = '{a, b, c, d};
        for (int i = 0; i < 16; i++) smp[i] = t[i/4];
    endtask

    task automatic fill_steps(input logic [15:0] a, b, c, d);
        logic [15:0] t [4];
        t = '{a, b, c, d};
        for (int i = 0; i < 16; i++) smp[i] = t[i%4];
    endtask

    task automatic start_run(input string tag, input logic [15:0] k, input logic put);
        bus.start   = 1'b1;
        bus.strike  = k;
        bus.put_sel = put;
        tick();
        bus.start = 1'b0;
        chk({tag, "_busy_run"}, bus.busy, 1);
        chk({tag, "_price_held"}, bus.price, prev_price);
    endtask

    task automatic run_seq(input string tag, input logic [15:0] k, input logic put,
                           input int max_gap, input int mid_start, input logic [15:0] exp);
        int gaps;
        start_run(tag, k, put);
        for (int i = 0; i < 16; i++) begin
            gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gaps) begin
                bus.path_valid = 1'b0;
                bus.path       = 16'($urandom);
                tick();
            end
            bus.path_valid = 1'b1;
            bus.path       = smp[i];
            if (i == mid_start) begin
                bus.start  = 1'b1;
                bus.strike = 16'h0000;
            end
            tick();
            bus.start  = 1'b0;
            bus.strike = k;
        end
        bus.path_valid = 1'b0;
        chk({tag, "_t1_busy"}, bus.busy, 1);
        chk({tag, "_t1_pv"}, bus.price_valid, 0);
        tick();
        chk({tag, "_t2_pv"}, bus.price_valid, 1);
        chk({tag, "_t2_busy"}, bus.busy, 0);
        chk({tag, "_price"}, bus.price, exp);
        tick();
        chk({tag, "_t3_pv"}, bus.price_valid, 0);
        prev_price = exp;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.strike     = '0;
        bus.put_sel    = 1'b0;
        bus.path_valid = 1'b0;
        bus.path       = '0;
        prev_price     = '0;
        repeat (3) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_pv", bus.price_valid, 0);
        chk("rst_price", bus.price, 0);
        rst_n = 1'b1;
        tick();

        // samples repeat the terminal value so the Asian build prices these the same
        fill_term(16'h6A00, 16'h6400, 16'h6000, 16'h7000);
        run_seq("call", 16'h6400, 1'b0, 0, -1, 16'h0480);
        run_seq("put", 16'h6400, 1'b1, 0, -1, 16'h0100);
        run_seq("gaps", 16'h6400, 1'b0, 5, -1, 16'h0480);
        run_seq("midstart", 16'h6400, 1'b0, 0, 7, 16'h0480);

        start_run("rstmid", 16'h6400, 1'b0);
        for (int i = 0; i < 6; i++) begin
            bus.path_valid = 1'b1;
            bus.path       = smp[i];
            tick();
        end
        bus.path_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", bus.busy, 0);
        chk("rstmid_price", bus.price, 0);
        chk("rstmid_pv", bus.price_valid, 0);
        tick();
        rst_n = 1'b1;
        prev_price = '0;
        tick();
        run_seq("after_rst", 16'h6400, 1'b1, 0, -1, 16'h0100);

        fill_term(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        run_seq("max_k0", 16'h0000, 1'b0, 0, -1, 16'hFFFF);
        run_seq("max_kmax", 16'hFFFF, 1'b0, 0, -1, 16'h0000);

        fill_steps(16'h6000, 16'h6800, 16'h7000, 16'h7800);
`ifdef ASIAN_PAYOFF_EN
        run_seq("asian", 16'h6400, 1'b0, 2, -1, 16'h0800);
`else
        run_seq("euro", 16'h6400, 1'b0, 2, -1, 16'h1400);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
